// File: rtl/set_bit_serializer_pkg.sv
// Shared types and constants for the set-bit serializer and its encoder.
//
// Contents:
//   state_e        FSM state encoding (IDLE, SCAN, EMPTY)
//   DEFAULT_WIDTH  default request vector width
//   pos_width()    output position width, with room for the sentinel value WIDTH
//   NO_BIT         "no bit set" sentinel for the default width
package set_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMPTY = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // One extra bit so that the sentinel value WIDTH can be encoded.
  function automatic int unsigned pos_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned NO_BIT = DEFAULT_WIDTH;

endpackage

// File: rtl/set_bit_serializer_encoder.sv
// lowest_set_encoder: combinational lowest-set-bit encoder, shared with the
// upstream detector stage.
//
// Ports:
//   vec_i          input vector
//   pos_o          index of the lowest set bit, or WIDTH when vec_i is zero
//   mask_o         one-hot mask of the lowest set bit (zero when vec_i is zero)
//   onehot_only_o  vec_i has exactly one bit set
module lowest_set_encoder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned POS_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [POS_W-1:0] pos_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             onehot_only_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] vec_minus_one;

  always_comb begin
    // Scan high to low so the lowest set bit is the last one written.
    pos_o = POS_W'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        pos_o = POS_W'(i);
      end
    end
  end

  // Two's-complement trick isolates the lowest set bit; v & (v-1) clears it.
  assign vec_minus_one = vec_i - ONE;
  assign mask_o        = vec_i & (~vec_i + ONE);
  assign onehot_only_o = (vec_i != '0) && ((vec_i & vec_minus_one) == '0);

endmodule

// File: rtl/set_bit_serializer.sv
// set_bit_serializer: accepts a request vector and emits the positions of its
// set bits one per output handshake, lowest first. An all-zero vector produces
// a single sentinel position WIDTH with out_last set.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_vec/in_valid/in_ready      request vector handshake
//   out_pos/out_valid/out_ready   position handshake
//   out_last              current position is the final one of the vector
//   busy                  FSM is not in IDLE
//
// Build option SET_BIT_SERIALIZER_MERGE_EN: when defined, new vectors are also
// accepted during SCAN and ORed into the pending set.
module set_bit_serializer
  import set_bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned POS_W = pos_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic [POS_W-1:0] enc_pos;
  logic [WIDTH-1:0] enc_mask;
  logic             enc_onehot;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] merge_vec;

  lowest_set_encoder #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_enc (
    .vec_i         (pending_q),
    .pos_o         (enc_pos),
    .mask_o        (enc_mask),
    .onehot_only_o (enc_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_pos    = '0;
    out_last   = 1'b0;
    clear_mask = '0;
    merge_vec  = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = SCAN;
          end else begin
            state_d = EMPTY;
          end
        end
      end

      SCAN: begin
        out_valid = 1'b1;
        out_pos   = enc_pos;
        // out_last looks at pending only; a merge in the same cycle can still
        // refill the set and keep the FSM here.
        out_last  = enc_onehot;
`ifdef SET_BIT_SERIALIZER_MERGE_EN
        in_ready = 1'b1;
        if (in_valid) begin
          merge_vec = in_vec;
        end
`endif
        if (out_ready) begin
          clear_mask = enc_mask;
        end
        // Clear before OR so a bit emitted and re-requested together stays set.
        pending_d = (pending_q & ~clear_mask) | merge_vec;
        if (pending_d == '0) begin
          state_d = IDLE;
        end
      end

      EMPTY: begin
        out_valid = 1'b1;
        out_pos   = POS_W'(WIDTH);
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_set_bit_serializer.sv
module tb_set_bit_serializer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned POS_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [POS_W-1:0] out_pos;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  set_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pos   (out_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: positions of all set bits ascending, or the sentinel for zero.
  task automatic expected_positions(input logic [WIDTH-1:0] vec, output int q[$]);
    q = {};
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) q.push_back(i);
    end
    if (q.size() == 0) q.push_back(WIDTH);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_in_ready"},  32'(in_ready),  1);
  endtask

  // Load one vector and drain it. mode 0: always ready; 1: random stalls;
  // 2: ready held low for the first 3 cycles.
  task automatic run_vector(input logic [WIDTH-1:0] vec, input int mode, input string tag);
    int exp_q[$];
    int idx;
    int cycles;
    logic rdy;
    expected_positions(vec, exp_q);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 1);
    in_vec   = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_vec   = $urandom();
    idx    = 0;
    cycles = 0;
    while (idx < exp_q.size() && cycles < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = (cycles >= 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      chk({tag, "_out_valid"}, 32'(out_valid), 1);
      chk({tag, "_out_pos"},   32'(out_pos),   32'(exp_q[idx]));
      chk({tag, "_out_last"},  32'(out_last),  32'(idx == exp_q.size() - 1));
      chk({tag, "_busy"},      32'(busy),      1);
`ifndef SET_BIT_SERIALIZER_MERGE_EN
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 0);
`endif
      step();
      if (rdy) idx++;
      cycles++;
    end
    out_ready = 1'b0;
    if (cycles >= 400) chk({tag, "_timeout"}, 1, 0);
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    reset     = 1'b1;
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pos",   32'(out_pos),   0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_in_ready",  32'(in_ready),  1);
    @(negedge clk);
    reset = 1'b0;
    step();

    run_vector(32'h1000_1000, 0, "t1_two_bits");
    step();
    run_vector(32'h0000_0000, 0, "t2_empty");
    run_vector(32'h0000_0005, 2, "t3_stall");
    step();
    run_vector(32'hFFFF_FFFF, 0, "t4_all_ones");
    run_vector(32'h8000_0000, 0, "t_top_bit");
    run_vector(32'h0000_0001, 1, "t_bottom_bit");

    // Reset while the second position is still being presented.
    chk("t5_in_ready", 32'(in_ready), 1);
    in_vec   = 32'h1100_0000;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_pos0", 32'(out_pos), 24);
    step();
    out_ready = 1'b0;
    chk("t5_pos1", 32'(out_pos), 28);
    chk("t5_last1", 32'(out_last), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_out_pos",   32'(out_pos),   0);
    chk("t5_rst_out_last",  32'(out_last),  0);
    chk("t5_rst_busy",      32'(busy),      0);
    chk("t5_rst_in_ready",  32'(in_ready),  1);
    @(negedge clk);
    reset = 1'b0;
    step();
    // Stale pending bit 28 must not reappear.
    run_vector(32'h0000_0001, 0, "t5_after_reset");

`ifdef SET_BIT_SERIALIZER_MERGE_EN
    in_vec   = 32'h0000_0010;
    in_valid = 1'b1;
    step();
    chk("t6_pos4", 32'(out_pos), 4);
    chk("t6_last4", 32'(out_last), 1);
    chk("t6_in_ready", 32'(in_ready), 1);
    in_vec    = 32'h0000_0011;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_valid_a", 32'(out_valid), 1);
    chk("t6_pos_a",   32'(out_pos),   0);
    chk("t6_last_a",  32'(out_last),  0);
    step();
    chk("t6_valid_b", 32'(out_valid), 1);
    chk("t6_pos_b",   32'(out_pos),   4);
    chk("t6_last_b",  32'(out_last),  1);
    step();
    out_ready = 1'b0;
    check_idle("t6_after");
`endif

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0:       rv = '0;
        1:       rv = 32'hFFFF_FFFF;
        2:       rv = 32'(1) << $urandom_range(0, WIDTH - 1);
        3:       rv = $urandom() & $urandom() & $urandom();
        default: rv = $urandom();
      endcase
      run_vector(rv, 1, "rand");
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
